rv_lane_serializer: RTL

RV_LANE_SERIALIZER -- requirements
Module: RV_lane_serializer

---
 rtl/rv_lane_serializer.sv | 113 +++++++++++
 1 files changed

// File: rtl/rv_lane_serializer.sv
// Serializes a thread mask into one beat per active lane, lowest lane first,
// carrying the mask's tag and popcount on every beat.
module rv_lane_serializer #(
  parameter int unsigned N    = 4,
  parameter int unsigned TAGW = 8,
  parameter int unsigned M    = $clog2(N + 1),
  parameter int unsigned LW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [N-1:0]    mask_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [LW-1:0]   lane_o,
  output logic [M-1:0]    beat_o,
  output logic [M-1:0]    cnt_o,
  output logic [TAGW-1:0] tag_o,
  output logic            last_o,
  input  logic            ready_i
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [M-1:0]    cnt_q, cnt_d;
  logic [M-1:0]    beat_q, beat_d;

  logic [N-1:0]    mask_rest;
  logic [M-1:0]    pop_cnt;
  logic [LW-1:0]   low_lane;
  logic            busy;
  logic            pop;
  logic            accept;

  // Pending mask with its lowest set bit cleared; zero means one bit is left.
  assign mask_rest = mask_q & (mask_q - N'(1));
  assign busy      = (state_q == StBusy);

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      pop_cnt = pop_cnt + M'(mask_i[i]);
    end
  end

  always_comb begin
    low_lane = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_lane = LW'(i);
      end
    end
  end

  assign valid_o = busy;
  assign last_o  = busy && (mask_q != '0) && (mask_rest == '0);
  assign lane_o  = low_lane;
  assign beat_o  = beat_q;
  assign cnt_o   = cnt_q;
  assign tag_o   = tag_q;
  assign ready_o = !busy || (valid_o && ready_i && last_o);

  assign pop    = valid_o && ready_i;
  assign accept = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    if (pop) begin
      mask_d = mask_rest;
      beat_d = beat_q + M'(1);
      if (last_o) begin
        state_d = StIdle;
      end
    end
    if (accept) begin
      if (mask_i != '0) begin
        state_d = StBusy;
        mask_d  = mask_i;
        tag_d   = tag_i;
        cnt_d   = pop_cnt;
        beat_d  = '0;
      end else begin
        // Empty masks are swallowed; pending mask is already zero here.
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mask_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

endmodule
